// File: rtl/regfile_rd_port.sv
// Integer register file (32 x XLEN, x0 = 0) with one write-back port, two registered read ports and a pending-write scoreboard.
// Latency: read data 1 cycle after address, with write-through bypass from the same-cycle write-back; STALL is combinational.
// Backpressure: RD_EN=0 freezes both read outputs (decode stall); the array and scoreboard keep updating regardless.
//
// Ports:
//   CLK, RST_N           clock, asynchronous active-low reset
//   WB_WE/WB_WA/WB_WD    write-back port (writes to x0 are dropped)
//   RD_EN                read-output update enable
//   RS1_A/RS2_A          read addresses; RS1_D/RS2_D registered read data
//   ISS_V/ISS_RD         issue of an instruction that will later write ISS_RD (sets busy)
//   STALL                an operand address has a pending write not landing this cycle
// Optional build macro RF_DEBUG_PORT_EN adds DBG_A/DBG_D (raw array peek, no bypass)
// and DBG_BUSY (live busy vector). Without it those ports and their logic do not exist.
module regfile_rd_port #(
    parameter int XLEN = 32,
    parameter int NREG = 32,
    parameter int AW   = 5
) (
    input  logic            CLK,
    input  logic            RST_N,
    input  logic            WB_WE,
    input  logic [AW-1:0]   WB_WA,
    input  logic [XLEN-1:0] WB_WD,
    input  logic            RD_EN,
    input  logic [AW-1:0]   RS1_A,
    input  logic [AW-1:0]   RS2_A,
    output logic [XLEN-1:0] RS1_D,
    output logic [XLEN-1:0] RS2_D,
    input  logic            ISS_V,
    input  logic [AW-1:0]   ISS_RD,
    output logic            STALL
`ifdef RF_DEBUG_PORT_EN
    ,
    input  logic [AW-1:0]   DBG_A,
    output logic [XLEN-1:0] DBG_D,
    output logic [NREG-1:0] DBG_BUSY
`endif
);

    logic [XLEN-1:0] regs_q [NREG];
    logic [NREG-1:0] busy_q, busy_d;
    logic [XLEN-1:0] rs1_q, rs1_d;
    logic [XLEN-1:0] rs2_q, rs2_d;

    logic wb_ok;
    logic clr1, clr2;

    // A write-back to x0 is architecturally a no-op for both array and scoreboard.
    assign wb_ok = WB_WE && (WB_WA != '0);

    // The pending write for an operand lands this cycle and is forwarded by the bypass.
    assign clr1 = WB_WE && (WB_WA == RS1_A);
    assign clr2 = WB_WE && (WB_WA == RS2_A);

    // busy_q[0] is held at 0, so address 0 can never stall.
    assign STALL = (busy_q[RS1_A] && !clr1) || (busy_q[RS2_A] && !clr2);

    // Read data next-state: x0 reads 0, then same-cycle write-back wins over stale contents.
    always_comb begin
        rs1_d = rs1_q;
        rs2_d = rs2_q;
        if (RD_EN) begin
            if (RS1_A == '0)
                rs1_d = '0;
            else if (wb_ok && (WB_WA == RS1_A))
                rs1_d = WB_WD;
            else
                rs1_d = regs_q[RS1_A];

            if (RS2_A == '0)
                rs2_d = '0;
            else if (wb_ok && (WB_WA == RS2_A))
                rs2_d = WB_WD;
            else
                rs2_d = regs_q[RS2_A];
        end
    end

    // Scoreboard: clear on write-back first, then set on issue so the younger issue wins a collision.
    always_comb begin
        busy_d = busy_q;
        if (wb_ok)
            busy_d[WB_WA] = 1'b0;
        if (ISS_V && (ISS_RD != '0))
            busy_d[ISS_RD] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= '0;
            busy_q <= '0;
            rs1_q  <= '0;
            rs2_q  <= '0;
        end else begin
            if (wb_ok)
                regs_q[WB_WA] <= WB_WD;
            busy_q <= busy_d;
            rs1_q  <= rs1_d;
            rs2_q  <= rs2_d;
        end
    end

    assign RS1_D = rs1_q;
    assign RS2_D = rs2_q;

`ifdef RF_DEBUG_PORT_EN
    // Raw array view; regs_q[0] is never written so x0 reads 0 without extra muxing.
    assign DBG_D    = regs_q[DBG_A];
    assign DBG_BUSY = busy_q;
`endif

endmodule
